// File: rtl/sram_pkg.sv
// Shared types and helpers for the lane-masked single-port SRAM buffer.
package sram_pkg;

  // Response words are carried at a fixed maximum width; DATA_W must not exceed it.
  localparam int RESP_MAX_W = 64;

  typedef struct packed {
    logic [RESP_MAX_W-1:0] rdata;
    logic                  perr;
  } resp_t;

  function automatic logic even_parity(input logic [RESP_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sram_1rw_core.sv
// Raw 1RW array: lane-masked writes at accept, registered read address, combinational read data.
// With SRAM_PARITY_EN defined each lane carries an even-parity bit checked on read.
module sram_1rw_core
  import sram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 36,
  parameter int LANE_W = 9,
  parameter int NLANE  = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NLANE-1:0]  wmask,
  output resp_t             rsp
);

`ifdef SRAM_PARITY_EN
  localparam int WORD_W = DATA_W + NLANE;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] raddr_q;
  logic              oob_q;
  logic              in_range;
  logic [WORD_W-1:0] word;

  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

  // The array is deliberately not reset; read-address state is qualified by the caller's valid bits.
  always_ff @(posedge clk) begin
    if (en && we && in_range) begin
      for (int l = 0; l < NLANE; l++) begin
        if (wmask[l]) begin
          mem[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
`ifdef SRAM_PARITY_EN
          mem[addr][DATA_W+l] <= even_parity(RESP_MAX_W'(wdata[l*LANE_W +: LANE_W]));
`endif
        end
      end
    end
    if (en && !we) begin
      raddr_q <= addr;
      oob_q   <= !in_range;
    end
  end

  assign word = mem[raddr_q];

  always_comb begin
    rsp = '0;
    if (!oob_q) begin
      rsp.rdata[DATA_W-1:0] = word[DATA_W-1:0];
`ifdef SRAM_PARITY_EN
      for (int l = 0; l < NLANE; l++) begin
        rsp.perr = rsp.perr |
                   (even_parity(RESP_MAX_W'(word[l*LANE_W +: LANE_W])) ^ word[DATA_W+l]);
      end
`endif
    end
  end

endmodule

// File: rtl/sram_1rw_masked_buf.sv
// Credit-flow-controlled SRAM wrapper: 1RW core, optional output register (RD_LAT=2), in-order
// response FIFO with fall-through when empty. Parity checking is enabled by SRAM_PARITY_EN.
module sram_1rw_masked_buf
  import sram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 36,
  parameter int LANE_W = 9,
  parameter int RD_LAT = 1,
  parameter int NLANE  = DATA_W / LANE_W
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wmode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NLANE-1:0]  req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_perr
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready depends only on the credit count, resp_valid only on internal state.
  localparam int FDEPTH = RD_LAT + 1;
  localparam int CRED_W = $clog2(RD_LAT + 2);
  localparam int PTR_W  = $clog2(FDEPTH);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RD_LAT + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FDEPTH - 1);

  logic              req_fire, rd_fire, pop, push, rd_v1;
  logic [CRED_W-1:0] credit, count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  resp_t             core_rsp, push_rsp, head;
  resp_t             fifo_mem [FDEPTH];
  logic              unused_head;

  assign req_ready = (credit != '0);
  assign req_fire  = req_valid & req_ready;
  assign rd_fire   = req_fire & ~req_wmode;
  assign pop       = resp_valid & resp_ready;

  sram_1rw_core #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LANE_W(LANE_W)
  ) u_core (
    .clk  (RW0_clk),
    .en   (req_fire),
    .we   (req_wmode),
    .addr (req_addr),
    .wdata(req_wdata),
    .wmask(req_wmask),
    .rsp  (core_rsp)
  );

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) rd_v1 <= 1'b0;
    else            rd_v1 <= rd_fire;
  end

  if (RD_LAT == 2) begin : g_lat2
    resp_t out_q;
    logic  rd_v2;
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
      if (!RW0_rst_n) rd_v2 <= 1'b0;
      else            rd_v2 <= rd_v1;
    end
    always_ff @(posedge RW0_clk) begin
      if (rd_v1) out_q <= core_rsp;
    end
    assign push     = rd_v2;
    assign push_rsp = out_q;
  end else begin : g_lat1
    assign push     = rd_v1;
    assign push_rsp = core_rsp;
  end

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      credit <= CRED_MAX;
    end else begin
      unique case ({rd_fire, pop})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   credit <= credit + 1'b1;
        default: ;
      endcase
    end
  end

  // Every arriving response is stored; when the FIFO is empty it is also presented directly,
  // so a same-cycle pop simply advances both pointers.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CRED_W'(push) - CRED_W'(pop);
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_rsp;
  end

  assign head        = (count == '0) ? push_rsp : fifo_mem[rd_ptr];
  assign resp_valid  = (count != '0) | push;
  assign resp_rdata  = head.rdata[DATA_W-1:0];
  assign unused_head = ^{head.rdata, head.perr};

`ifdef SRAM_PARITY_EN
  assign resp_perr = head.perr;
`else
  assign resp_perr = 1'b0;
`endif

endmodule
